// File: rtl/sync_comparator_pkg.sv
// -----------------------------------------------------------------------------
// sync_comparator_pkg
// Shared types for the registered three-way magnitude comparator.
//   cmp_flags_t : one-hot compare result {gt, lt, eq} as held in the output
//                 register of sync_comparator.
// -----------------------------------------------------------------------------
package sync_comparator_pkg;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_flags_t;

endpackage : sync_comparator_pkg

// File: rtl/sync_comparator_merge_cell.sv
// -----------------------------------------------------------------------------
// comparator_merge_cell
// Purely combinational merge node of the compare tree. Combines the partial
// result of a more-significant half (hi_*) with a less-significant half (lo_*).
// The high half decides unless it is equal, in which case the low half decides.
// Ports:
//   hi_gt, hi_eq : partial result of the high half
//   lo_gt, lo_eq : partial result of the low half
//   gt, eq       : merged partial result
// -----------------------------------------------------------------------------
module comparator_merge_cell (
    input  logic hi_gt,
    input  logic hi_eq,
    input  logic lo_gt,
    input  logic lo_eq,
    output logic gt,
    output logic eq
);

    assign gt = hi_gt | (hi_eq & lo_gt);
    assign eq = hi_eq & lo_eq;

endmodule : comparator_merge_cell

// File: rtl/sync_comparator.sv
// -----------------------------------------------------------------------------
// sync_comparator
// Parameterised magnitude comparator with registered one-hot gt/lt/eq flags,
// one cycle of latency and one compare per cycle.
// Parameters:
//   IP_WIDTH  : operand width in bits (>= 1)
//   IS_SIGNED : 0 = unsigned compare, 1 = two's-complement compare
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset, clears all outputs
//   a, b      : operands
//   in_valid  : operands valid, a compare is captured on this edge
//   gt/lt/eq  : registered result of the most recent captured compare
//   out_valid : gt/lt/eq were updated on the last edge
// -----------------------------------------------------------------------------
module sync_comparator #(
    parameter int IP_WIDTH  = 1,
    parameter int IS_SIGNED = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IP_WIDTH-1:0] a,
    input  logic [IP_WIDTH-1:0] b,
    input  logic                in_valid,
    output logic                gt,
    output logic                lt,
    output logic                eq,
    output logic                out_valid
);

    import sync_comparator_pkg::*;

    localparam int DEPTH  = $clog2(IP_WIDTH);
    localparam int LEAVES = 1 << DEPTH;

    // Unused leaves beyond IP_WIDTH look like an equal bit pair so they never
    // influence the result.
    localparam logic PAD_GT = 1'b0;
    localparam logic PAD_EQ = 1'b1;

    // Flipping both MSBs maps two's-complement order onto unsigned order.
    localparam logic [IP_WIDTH-1:0] MSB_MASK =
        (IS_SIGNED != 0) ? (IP_WIDTH'(1) << (IP_WIDTH - 1)) : '0;

    logic [IP_WIDTH-1:0] a_u;
    logic [IP_WIDTH-1:0] b_u;

    // Heap-ordered tree: node i has children 2i (high half) and 2i+1 (low
    // half); node 1 is the root. Leaves occupy LEAVES..2*LEAVES-1 with the
    // most significant bit at the lowest leaf index.
    logic node_gt [1:2*LEAVES-1];
    logic node_eq [1:2*LEAVES-1];

    logic root_gt;
    logic root_eq;

    cmp_flags_t flags_p1;
    logic       vld_p1;

    // ---- stage 0: operand mapping, leaves and merge tree (combinational) ----
    assign a_u = a ^ MSB_MASK;
    assign b_u = b ^ MSB_MASK;

    for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
        if (j < IP_WIDTH) begin : g_bit
            assign node_gt[2*LEAVES-1-j] = a_u[j] & ~b_u[j];
            assign node_eq[2*LEAVES-1-j] = ~(a_u[j] ^ b_u[j]);
        end else begin : g_pad
            assign node_gt[2*LEAVES-1-j] = PAD_GT;
            assign node_eq[2*LEAVES-1-j] = PAD_EQ;
        end
    end

    for (genvar i = 1; i < LEAVES; i++) begin : g_merge
        comparator_merge_cell u_merge (
            .hi_gt (node_gt[2*i]),
            .hi_eq (node_eq[2*i]),
            .lo_gt (node_gt[2*i+1]),
            .lo_eq (node_eq[2*i+1]),
            .gt    (node_gt[i]),
            .eq    (node_eq[i])
        );
    end

    assign root_gt = node_gt[1];
    assign root_eq = node_eq[1];

    // ---- stage 1: output registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_p1 <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                flags_p1.gt <= root_gt;
                flags_p1.lt <= ~root_gt & ~root_eq;
                flags_p1.eq <= root_eq;
            end
        end
    end

    assign gt        = flags_p1.gt;
    assign lt        = flags_p1.lt;
    assign eq        = flags_p1.eq;
    assign out_valid = vld_p1;

endmodule : sync_comparator

// File: tb/tb_sync_comparator.sv
// -----------------------------------------------------------------------------
// tb_sync_comparator
// Bench for sync_comparator. Seven instances cover widths 1, 3, 4 (both
// signedness modes) and width 5 unsigned. Each instance has its own driver,
// expected-result queue and monitor; the monitor pops an entry whenever the
// DUT raises out_valid.
// -----------------------------------------------------------------------------
module tb_sync_comparator;

    localparam int NCFG = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W = (g < 2) ? 1 : (g < 4) ? 3 : (g < 6) ? 4 : 5;
        localparam int S = (g == 1 || g == 3 || g == 5) ? 1 : 0;

        logic         rst = 1'b1;
        logic [W-1:0] a   = '0;
        logic [W-1:0] b   = '0;
        logic         vld = 1'b0;
        logic         gt, lt, eq, outv;
        logic [2:0]   q [$];

        sync_comparator #(
            .IP_WIDTH  (W),
            .IS_SIGNED (S)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .a         (a),
            .b         (b),
            .in_valid  (vld),
            .gt        (gt),
            .lt        (lt),
            .eq        (eq),
            .out_valid (outv)
        );

        // Reference value of a W-bit pattern in the configured number system.
        function automatic int sval(input int x);
            if (S != 0 && x >= (1 << (W - 1)))
                return x - (1 << W);
            return x;
        endfunction

        // Drive one compare and record its expected {gt,lt,eq}; returns 1
        // time unit after the capturing edge.
        task automatic send(input int x, input int y, input logic [2:0] e);
            a   = x[W-1:0];
            b   = y[W-1:0];
            vld = 1'b1;
            q.push_back(e);
            @(posedge clk);
            #1;
        endtask

        // Monitor: compare every presented result against the queue head.
        always @(negedge clk) begin
            if (outv) begin
                if (q.size() == 0) begin
                    chk($sformatf("W%0dS%0d unexpected_out_valid", W, S), 32'(outv), 32'd0);
                end else begin
                    chk($sformatf("W%0dS%0d result", W, S), 32'({gt, lt, eq}), 32'(q.pop_front()));
                end
                chk($sformatf("W%0dS%0d onehot", W, S), 32'($countones({gt, lt, eq})), 32'd1);
            end
        end

        initial begin
            // Reset state
            @(posedge clk);
            #1;
            chk($sformatf("W%0dS%0d reset_flags", W, S), 32'({gt, lt, eq, outv}), 32'd0);
            @(posedge clk);
            #1;
            rst = 1'b0;

            // Hand-computed directed vectors, {gt,lt,eq}
            if (W == 4 && S == 0) begin
                send(9, 3, 3'b100);
                send(3, 9, 3'b010);
                send(15, 15, 3'b001);
            end
            if (W == 4 && S == 1) begin
                send(4'b1000, 4'b0111, 3'b010);
                send(4'b1111, 4'b0000, 3'b010);
                send(4'b0001, 4'b1110, 3'b100);
            end
            if (W == 1 && S == 1) begin
                send(1, 0, 3'b010);
            end
            if (W == 5) begin
                send(16, 15, 3'b100);
                send(31, 31, 3'b001);
            end

            // Exhaustive back-to-back sweep
            if (W != 5) begin
                for (int x = 0; x < (1 << W); x++) begin
                    for (int y = 0; y < (1 << W); y++) begin
                        send(x, y, {sval(x) > sval(y), sval(x) < sval(y), sval(x) == sval(y)});
                    end
                end
            end

            if (W == 4 && S == 0) begin
                // Hold: in_valid low keeps the flags and clears out_valid
                send(9, 3, 3'b100);
                vld = 1'b0;
                a   = 4'd0;
                b   = 4'd5;
                @(posedge clk);
                #1;
                chk("hold_flags", 32'({gt, lt, eq}), 32'b100);
                chk("hold_out_valid", 32'(outv), 32'd0);

                // Asynchronous reset between edges while eq is showing
                send(15, 15, 3'b001);
                vld = 1'b0;
                #6;
                chk("pre_reset_eq", 32'({eq, outv}), 32'b11);
                rst = 1'b1;
                #1;
                chk("async_reset_flags", 32'({gt, lt, eq, outv}), 32'd0);
                rst = 1'b0;
                @(posedge clk);
                #1;
                chk("post_reset_idle", 32'(outv), 32'd0);
                send(2, 5, 3'b010);
                chk("post_reset_first", 32'({outv, lt}), 32'b11);
            end

            vld = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1;
            chk($sformatf("W%0dS%0d drained", W, S), 32'(q.size()), 32'd0);
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 5000 && done_cnt < NCFG; i++) @(posedge clk);
        #2;
        if (done_cnt < NCFG) begin
            failures++;
            $display("FAIL timeout done=%0d expected=%0d", done_cnt, NCFG);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_comparator
